// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with per-frame shadowing,
// PWM brightness, anti-ghost dead time and a frame-done strobe.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [63:0] seg_data,
  input  logic [3:0]  bright,
  input  logic        blank,
  output logic [7:0]  seg_n,
  output logic [7:0]  dig_n,
  output logic        frame_done
);

  // Legal range: SCAN_DIV >= 2 and DEAD_CYC < SCAN_DIV.
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam bit HAS_DEAD = (DEAD_CYC > 0);

  typedef enum logic {
    S_DEAD = 1'b0,
    S_ON   = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [2:0]       digit, digit_next;
  logic [CNT_W-1:0] slot_cnt, cnt_next;
  logic [3:0]       pwm_cnt, pwm_next;
  logic [63:0]      shadow_data, data_next;
  logic [3:0]       shadow_bright, bright_next;
  logic [7:0]       seg_n_next, dig_n_next, seg_byte;
  logic             frame_done_next;
  logic             slot_wrap, frame_start, gap, lit_next;

  always_comb begin
    state_next = state;
    slot_wrap  = (slot_cnt == CNT_LAST);
    cnt_next   = slot_wrap ? '0 : slot_cnt + 1'b1;
    digit_next = slot_wrap ? digit + 3'd1 : digit;
    pwm_next   = (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;

    case (state)
      S_DEAD: if (!HAS_DEAD || slot_cnt == DEAD_LAST) state_next = S_ON;
      S_ON:   if (slot_wrap && HAS_DEAD) state_next = S_DEAD;
      default: state_next = S_DEAD;
    endcase

    // Shadows are captured during the first cycle of digit 0's slot; the
    // outputs for the following cycle must already see the captured values.
    frame_start = (digit == 3'd0) && (slot_cnt == '0);
    data_next   = frame_start ? seg_data : shadow_data;
    bright_next = frame_start ? bright : shadow_bright;

    // Without a dead window, the first cycle of every slot is kept dark so
    // two digits are never lit back to back.
    gap      = !HAS_DEAD && (cnt_next == '0);
    lit_next = (state_next == S_ON) && !gap && !blank && (pwm_next < bright_next);

    seg_byte   = data_next[{digit_next, 3'b000} +: 8];
    seg_n_next = lit_next ? ~seg_byte : 8'hFF;
    dig_n_next = lit_next ? ~(8'b1 << digit_next) : 8'hFF;

    frame_done_next = (digit_next == 3'd7) && (cnt_next == CNT_LAST);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state         <= S_DEAD;
      digit         <= 3'd0;
      slot_cnt      <= '0;
      pwm_cnt       <= 4'd0;
      shadow_data   <= 64'd0;
      shadow_bright <= 4'd0;
      seg_n         <= 8'hFF;
      dig_n         <= 8'hFF;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_next;
      digit         <= digit_next;
      slot_cnt      <= cnt_next;
      pwm_cnt       <= pwm_next;
      shadow_data   <= data_next;
      shadow_bright <= bright_next;
      seg_n         <= seg_n_next;
      dig_n         <= dig_n_next;
      frame_done    <= frame_done_next;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz).
REQ-002 SHALL have parameter DEAD_CYC, default 500: anti-ghosting cycles at the start of each slot with all digits off.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port seg_data, input, 64 bits: byte i drives digit i; bits 6:0 are segments a-g, bit 7 is dp; 1 = lit. Sourced from the kernel's seg7 conduit.
REQ-006 SHALL have port bright, input, 4 bits: brightness, 0 = off, 15 = full.
REQ-007 SHALL have port blank, input, 1 bit: force the display dark.
REQ-008 SHALL have port seg_n, output, 8 bits: segment drive, active-low, same bit order as seg_data bytes.
REQ-009 SHALL have port dig_n, output, 8 bits: digit select, active-low, bit i = digit i.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit 7's slot ends.

Function
REQ-011 SHALL require 2 <= SCAN_DIV and DEAD_CYC < SCAN_DIV; slot counter width SHALL be clog2(SCAN_DIV).
REQ-012 SHALL implement states DEAD and ON, plus a 3-bit digit index and a slot counter.
  - DEAD lasts DEAD_CYC cycles, then ON lasts SCAN_DIV-DEAD_CYC cycles.
  - At the end of ON, the digit index advances 7->0 with wrap and the state returns to DEAD.
REQ-013 SHALL skip DEAD (enter ON directly) when DEAD_CYC = 0.
REQ-014 SHALL load shadow registers from seg_data and bright on the first cycle of digit 0's DEAD state (frame start) only.
  - Changes at any other time SHALL be invisible until the next frame start.
REQ-015 SHALL run a free-running 4-bit pwm_cnt that counts 0..14 and wraps to 0; it is not reset by slot or frame boundaries.
REQ-016 SHALL register seg_n and dig_n, and SHALL compute them from the next-state values so that they change on the same edge that the state changes.
REQ-017 SHALL drive the outputs as follows:
  - In ON with lit = (pwm_cnt < shadow_bright) and blank = 0: dig_n = ~(8'b1 << digit) and seg_n = ~shadow_data[digit].
  - Otherwise: dig_n = 8'hFF and seg_n = 8'hFF.
REQ-018 SHALL give shadow_bright = 15 100% duty (pwm_cnt never reaches 15) and shadow_bright = 0 all-dark.
REQ-019 SHALL let blank act within 1 cycle without stopping the counters, digit index or frame_done; deasserting blank resumes output at the current digit and slot position.
REQ-020 SHALL assert frame_done for exactly the one cycle in which the digit index wraps 7->0; exactly one pulse per 8*SCAN_DIV cycles.
REQ-021 SHALL never drive more than one dig_n bit low in any cycle.
REQ-022 SHALL force every dig_n bit high for at least 1 cycle between any two different digits being active, even when DEAD_CYC = 0.

Reset
REQ-023 SHALL, while reset_reset_n = 0 at a rising edge, set:
  - state = DEAD, digit = 0, slot counter = 0, pwm_cnt = 0;
  - shadow_data = 0, shadow_bright = 0;
  - seg_n = 8'hFF, dig_n = 8'hFF, frame_done = 0.
REQ-024 SHALL treat the first cycle after reset release as the frame start (REQ-014).
REQ-025 SHALL abandon any in-progress slot on reset assertion mid-frame, with no partial frame_done.

Verification (SCAN_DIV=8, DEAD_CYC=2)
REQ-026 Reset: hold reset_reset_n=0 for 3 cycles with seg_data=all 1s -> seg_n=FF, dig_n=FF, frame_done=0 throughout.
REQ-027 Scan: seg_data=64'h0102040810204080, bright=15, release reset -> cycles 0-1 dark; cycles 2-7 dig_n=FE, seg_n=7F; cycles 10-15 dig_n=FD, seg_n=BF; ... digit 7 dig_n=7F, seg_n=FE; frame_done high at cycle 63 only, then every 64 cycles.
REQ-028 Tearing: change seg_data to 64'hFF.. while digit 3 is on -> digits 3-7 of the current frame unchanged; seg_n=00 from the next frame's digit 0.
REQ-029 Dimming: bright=0 -> outputs FF for the entire frame; bright=7 -> during ON, dig_n is active exactly when pwm_cnt<7, checked against a reference model.
REQ-030 Blank/reset mid-op: assert blank during digit 2 ON -> FF next cycle; deassert -> digit 2 resumes and frame_done timing is unchanged. Assert reset during digit 5 -> FF next cycle; on release the scan restarts at digit 0, DEAD, with no frame_done.
